// File: rtl/pi_spi_link_pkg.sv
// Shared PI definitions: bus bundle, command/address layout and address step helper.
package pi_spi_link_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  dato;
        logic        oe;
        logic        we;
        logic        act;
        logic        we_sync;
    } pi_bus_t;

    localparam int         PI_CMD_WR     = 7;
    localparam int         PI_ADDR_BYTES = 4;
    localparam logic [7:0] PI_TX_IDLE    = 8'h00;

    // Byte-address auto-increment; wraps naturally at 2^32.
    function automatic logic [31:0] pi_addr_next(input logic [31:0] addr);
        return addr + 32'd1;
    endfunction

endpackage

// File: rtl/pi_spi_link_chk.sv
// Protocol checks on the link: no dropped SPI bytes, never read and write at once.
module pi_spi_link_chk (
    input logic clk,
    input logic rst_n,
    input logic ovf,
    input logic oe,
    input logic we
);

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !ovf);
    a_oe_we_excl:  assert property (@(posedge clk) disable iff (!rst_n) !(oe && we));

endmodule

// File: rtl/spi_sync_shifter.sv
// SPI mode-0 slave bit layer: input synchronisers, edge detection, RX/TX shifters.
module spi_sync_shifter #(
    parameter int SYNC_FF = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       spi_sck,
    input  logic       spi_ss,
    input  logic       spi_mosi,
    input  logic       tx_load,
    input  logic [7:0] tx_byte,
    output logic       spi_miso,
    output logic [7:0] rx_byte,
    output logic       rx_stb,
    output logic       ss_fall,
    output logic       ss_rise
);

    logic [SYNC_FF-1:0] sck_sync_r;
    logic [SYNC_FF-1:0] ss_sync_r;
    logic [SYNC_FF-1:0] mosi_sync_r;
    logic               sck_prev_r;
    logic               ss_prev_r;
    logic [2:0]         bit_cnt_r;
    logic [7:0]         rx_r;
    logic [7:0]         tx_r;
    logic               rx_stb_r;

    logic sck_s;
    logic ss_s;
    logic mosi_s;
    logic sck_rise_s;
    logic sck_fall_s;

    assign sck_s      = sck_sync_r[SYNC_FF-1];
    assign ss_s       = ss_sync_r[SYNC_FF-1];
    assign mosi_s     = mosi_sync_r[SYNC_FF-1];
    assign sck_rise_s = sck_s & ~sck_prev_r;
    assign sck_fall_s = ~sck_s & sck_prev_r;
    assign ss_fall    = ss_prev_r & ~ss_s;
    assign ss_rise    = ~ss_prev_r & ss_s;
    assign spi_miso   = tx_r[7];
    assign rx_byte    = rx_r;
    assign rx_stb     = rx_stb_r;

    // Synchroniser chains plus one delayed copy for edge detection (SS idles high).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync_r  <= '0;
            ss_sync_r   <= '1;
            mosi_sync_r <= '0;
            sck_prev_r  <= 1'b0;
            ss_prev_r   <= 1'b1;
        end else begin
            sck_sync_r  <= {sck_sync_r[SYNC_FF-2:0], spi_sck};
            ss_sync_r   <= {ss_sync_r[SYNC_FF-2:0], spi_ss};
            mosi_sync_r <= {mosi_sync_r[SYNC_FF-2:0], spi_mosi};
            sck_prev_r  <= sck_s;
            ss_prev_r   <= ss_s;
        end
    end

    // RX shifter and bit counter; the counter is held clear while deselected so a partial byte is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_r      <= 8'h00;
            bit_cnt_r <= 3'd0;
            rx_stb_r  <= 1'b0;
        end else begin
            rx_stb_r <= 1'b0;
            if (ss_s) begin
                bit_cnt_r <= 3'd0;
            end else if (sck_rise_s) begin
                rx_r      <= {rx_r[6:0], mosi_s};
                bit_cnt_r <= bit_cnt_r + 3'd1;
                if (bit_cnt_r == 3'd7) begin
                    rx_stb_r <= 1'b1;
                end
            end
        end
    end

    // TX shifter: the trailing falling edge of a byte (counter back at 0) must not shift, so a freshly loaded MSB stays on MISO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_r <= 8'h00;
        end else if (tx_load) begin
            tx_r <= tx_byte;
        end else if (!ss_s && sck_fall_s && (bit_cnt_r != 3'd0)) begin
            tx_r <= {tx_r[6:0], 1'b0};
        end
    end

endmodule

// File: rtl/pi_spi_link.sv
// SPI slave to PiBus bridge: command/address decode and auto-incrementing byte accesses.
module pi_spi_link
    import pi_spi_link_pkg::*;
#(
    parameter int ACC_CYC = 4,
    parameter int SYNC_FF = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       spi_sck,
    input  logic       spi_ss,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output pi_bus_t    pi,
    input  logic [7:0] pi_dati,
    output logic       busy
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_CMD, ST_ADDR, ST_WR, ST_RD_DUMMY, ST_RD, ST_ACC
    } state_t;

    localparam logic [3:0] ACC_LAST  = 4'(ACC_CYC);
    localparam logic [1:0] ADDR_LAST = 2'(PI_ADDR_BYTES - 1);

    state_t     state_r, state_s, ret_r, ret_s;
    logic       dir_wr_r, dir_wr_s;
    logic [1:0] byte_cnt_r, byte_cnt_s;
    logic [3:0] acc_cnt_r, acc_cnt_s;
    logic [7:0] rd_buf_r, rd_buf_s;
    logic       ss_end_r, ss_end_s;
    logic       restart_r, restart_s;
    logic       ovf_r, ovf_s;
    logic       busy_r;
    pi_bus_t    pi_r, pi_s;
    logic       launch_s;
    logic       tx_load_s;
    logic [7:0] tx_byte_s;
    logic [7:0] rx_byte_s;
    logic       rx_stb_s, ss_fall_s, ss_rise_s;

    spi_sync_shifter #(.SYNC_FF(SYNC_FF)) u_shifter (
        .clk      (clk),
        .rst_n    (rst_n),
        .spi_sck  (spi_sck),
        .spi_ss   (spi_ss),
        .spi_mosi (spi_mosi),
        .tx_load  (tx_load_s),
        .tx_byte  (tx_byte_s),
        .spi_miso (spi_miso),
        .rx_byte  (rx_byte_s),
        .rx_stb   (rx_stb_s),
        .ss_fall  (ss_fall_s),
        .ss_rise  (ss_rise_s)
    );

    pi_spi_link_chk u_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .ovf   (ovf_r),
        .oe    (pi_r.oe),
        .we    (pi_r.we)
    );

    assign pi   = pi_r;
    assign busy = busy_r;

    // State and datapath registers; reset drops the bus cycle immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            ret_r      <= ST_IDLE;
            dir_wr_r   <= 1'b0;
            byte_cnt_r <= 2'd0;
            acc_cnt_r  <= 4'd0;
            rd_buf_r   <= 8'h00;
            ss_end_r   <= 1'b0;
            restart_r  <= 1'b0;
            ovf_r      <= 1'b0;
            busy_r     <= 1'b0;
            pi_r       <= '0;
        end else begin
            state_r    <= state_s;
            ret_r      <= ret_s;
            dir_wr_r   <= dir_wr_s;
            byte_cnt_r <= byte_cnt_s;
            acc_cnt_r  <= acc_cnt_s;
            rd_buf_r   <= rd_buf_s;
            ss_end_r   <= ss_end_s;
            restart_r  <= restart_s;
            ovf_r      <= ovf_s;
            busy_r     <= (state_s != ST_IDLE);
            pi_r       <= pi_s;
        end
    end

    // Next-state and next-bus logic; SS edges always win over a byte strobe.
    always_comb begin
        state_s      = state_r;
        ret_s        = ret_r;
        dir_wr_s     = dir_wr_r;
        byte_cnt_s   = byte_cnt_r;
        acc_cnt_s    = acc_cnt_r;
        rd_buf_s     = rd_buf_r;
        ss_end_s     = ss_end_r;
        restart_s    = restart_r;
        ovf_s        = ovf_r;
        pi_s         = pi_r;
        pi_s.act     = 1'b0;
        pi_s.we_sync = 1'b0;
        tx_load_s    = 1'b0;
        tx_byte_s    = PI_TX_IDLE;
        launch_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                ovf_s     = 1'b0;
                ss_end_s  = 1'b0;
                restart_s = 1'b0;
                if (ss_fall_s) begin
                    state_s    = ST_CMD;
                    byte_cnt_s = 2'd0;
                    tx_load_s  = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CMD, ST_ADDR, ST_WR, ST_RD_DUMMY, ST_RD: begin
                if (ss_rise_s) begin
                    state_s   = ST_IDLE;
                    tx_load_s = 1'b1;
                end else if (ss_fall_s) begin
                    state_s    = ST_CMD;
                    byte_cnt_s = 2'd0;
                    tx_load_s  = 1'b1;
                end else if (rx_stb_s) begin
                    case (state_r)
                        ST_CMD: begin
                            dir_wr_s   = rx_byte_s[PI_CMD_WR];
                            byte_cnt_s = 2'd0;
                            state_s    = ST_ADDR;
                        end
                        ST_ADDR: begin
                            pi_s.addr  = {pi_r.addr[23:0], rx_byte_s};
                            byte_cnt_s = byte_cnt_r + 2'd1;
                            if (byte_cnt_r != ADDR_LAST) begin
                                state_s = ST_ADDR;
                            end else if (dir_wr_r) begin
                                state_s = ST_WR;
                            end else begin
                                launch_s = 1'b1;
                                ret_s    = ST_RD_DUMMY;
                            end
                        end
                        ST_WR: begin
                            pi_s.dato = rx_byte_s;
                            launch_s  = 1'b1;
                            ret_s     = ST_WR;
                        end
                        ST_RD_DUMMY, ST_RD: begin
                            tx_load_s = 1'b1;
                            tx_byte_s = rd_buf_r;
                            launch_s  = 1'b1;
                            ret_s     = ST_RD;
                        end
                        default: begin
                            state_s = ST_IDLE;
                        end
                    endcase
                end else begin
                    state_s = state_r;
                end
            end
            ST_ACC: begin
                // SS activity is remembered; the latest edge decides where we go once the cycle ends.
                ss_end_s  = (ss_end_r | ss_rise_s) & ~ss_fall_s;
                restart_s = (restart_r & ~ss_rise_s) | ss_fall_s;
                ovf_s     = ovf_r | rx_stb_s;
                if (acc_cnt_r == ACC_LAST) begin
                    pi_s.oe   = 1'b0;
                    pi_s.we   = 1'b0;
                    pi_s.addr = pi_addr_next(pi_r.addr);
                    rd_buf_s  = pi_r.oe ? pi_dati : rd_buf_r;
                    if (restart_s) begin
                        state_s    = ST_CMD;
                        byte_cnt_s = 2'd0;
                        tx_load_s  = 1'b1;
                    end else if (ss_end_s) begin
                        state_s   = ST_IDLE;
                        tx_load_s = 1'b1;
                    end else begin
                        state_s = ret_r;
                    end
                    ss_end_s  = 1'b0;
                    restart_s = 1'b0;
                end else begin
                    acc_cnt_s    = acc_cnt_r + 4'd1;
                    pi_s.we_sync = pi_r.we & (acc_cnt_r == (ACC_LAST - 4'd1));
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        // Launching an access: act for one cycle, strobe held until ACC_LAST.
        state_s   = launch_s ? ST_ACC : state_s;
        acc_cnt_s = launch_s ? 4'd1 : acc_cnt_s;
        pi_s.act  = launch_s;
        pi_s.oe   = pi_s.oe | (launch_s & ~dir_wr_r);
        pi_s.we   = pi_s.we | (launch_s & dir_wr_r);
    end

endmodule

// File: tb/tb_pi_spi_link.sv
// Bench for pi_spi_link: table of packets checked against a transaction-level model, plus hand-written corner sequences.
module tb_pi_spi_link;
    import pi_spi_link_pkg::*;

    localparam int ACC_CYC = 4;
    localparam int HALF    = 8;   // clk cycles per SCK half period

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       spi_sck = 1'b0;
    logic       spi_ss = 1'b1;
    logic       spi_mosi = 1'b0;
    logic       spi_miso;
    pi_bus_t    pi;
    logic [7:0] pi_dati;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    pi_spi_link #(.ACC_CYC(ACC_CYC), .SYNC_FF(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .spi_sck  (spi_sck),
        .spi_ss   (spi_ss),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .pi       (pi),
        .pi_dati  (pi_dati),
        .busy     (busy)
    );

    // Clock generation.
    always #5 clk = ~clk;

    // Target model: read data is a function of the address.
    assign pi_dati = pi.addr[7:0] ^ 8'h3C;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [7:0]  dato;
        int          len;
        int          acts;
        int          syncs;
        bit          first_act;
        bit          sync_last;
        bit          unstable;
    } burst_t;

    burst_t bursts[$];
    burst_t cur;
    bit     in_burst = 1'b0;
    int     stray = 0;

    // Bus monitor: collects each oe/we burst with its act/we_sync counts and stability.
    always @(negedge clk) begin
        if (!rst_n) begin
            in_burst = 1'b0;
        end else if (pi.oe || pi.we) begin
            if (!in_burst) begin
                in_burst      = 1'b1;
                cur.wr        = pi.we;
                cur.addr      = pi.addr;
                cur.dato      = pi.dato;
                cur.len       = 0;
                cur.acts      = 0;
                cur.syncs     = 0;
                cur.first_act = pi.act;
                cur.unstable  = 1'b0;
            end
            cur.len++;
            cur.acts  += int'(pi.act);
            cur.syncs += int'(pi.we_sync);
            cur.sync_last = pi.we_sync;
            if (pi.addr !== cur.addr || pi.dato !== cur.dato || pi.we !== cur.wr) cur.unstable = 1'b1;
        end else begin
            if (in_burst) begin
                bursts.push_back(cur);
                in_burst = 1'b0;
            end
            if (pi.act || pi.we_sync) stray++;
        end
    end

    // Watchdog.
    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic spi_bits(input logic [7:0] b, input int nb, output logic [7:0] r);
        r = 8'h00;
        for (int i = 7; i > 7 - nb; i--) begin
            spi_mosi = b[i];
            tick(HALF);
            r[i] = spi_miso;
            spi_sck = 1'b1;
            tick(HALF);
            spi_sck = 1'b0;
        end
    endtask

    // Clock a byte up to and including its 8th rising edge, leaving SCK high.
    task automatic spi_byte_hold(input logic [7:0] b);
        logic [7:0] r;
        spi_bits(b, 7, r);
        spi_mosi = b[0];
        tick(HALF);
        spi_sck = 1'b1;
    endtask

    task automatic spi_start();
        spi_ss = 1'b0;
        tick(HALF);
    endtask

    task automatic spi_stop();
        tick(HALF);
        spi_ss = 1'b1;
        tick(4 * HALF);
    endtask

    task automatic wait_bus(input string name);
        int t = 0;
        while (!(pi.oe || pi.we) && t < 50) begin
            tick(1);
            t++;
        end
        chk(name, 32'(pi.oe | pi.we), 32'd1);
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        int          n;        // bytes after the address (reads: includes the dummy)
        logic [31:0] data;     // write bytes, first byte in [31:24]
        logic [31:0] exp_end;  // pi.addr once the packet is over
    } vec_t;

    // One packet through the SPI pins, checked against the transaction model.
    task automatic run_packet(input vec_t v, input string tag);
        logic [7:0]  r;
        logic [7:0]  miso_q[$];
        logic [7:0]  cmd;
        logic [6:0]  junk;
        logic [7:0]  d;
        logic [7:0]  exp_miso;
        logic [31:0] a;
        int          nacc;
        bursts.delete();
        stray = 0;
        junk  = 7'($urandom);
        cmd   = {v.wr, junk};
        spi_start();
        spi_bits(cmd, 8, r);
        miso_q.push_back(r);
        for (int i = 0; i < 4; i++) begin
            spi_bits(v.addr[31-8*i -: 8], 8, r);
            miso_q.push_back(r);
        end
        for (int k = 0; k < v.n; k++) begin
            d = v.wr ? v.data[31-8*k -: 8] : 8'($urandom);
            spi_bits(d, 8, r);
            miso_q.push_back(r);
        end
        spi_stop();
        nacc = v.wr ? v.n : v.n + 1;
        chk($sformatf("%s.bursts", tag), 32'(bursts.size()), 32'(nacc));
        for (int i = 0; i < bursts.size() && i < nacc; i++) begin
            a = v.addr + 32'(i);
            chk($sformatf("%s.b%0d.addr", tag, i), bursts[i].addr, a);
            chk($sformatf("%s.b%0d.wr", tag, i), 32'(bursts[i].wr), 32'(v.wr));
            if (v.wr) chk($sformatf("%s.b%0d.dato", tag, i), 32'(bursts[i].dato), 32'(v.data[31-8*i -: 8]));
            chk($sformatf("%s.b%0d.len", tag, i), 32'(bursts[i].len), 32'(ACC_CYC));
            chk($sformatf("%s.b%0d.act", tag, i), {bursts[i].acts[15:0], 15'd0, bursts[i].first_act}, {16'd1, 15'd0, 1'b1});
            chk($sformatf("%s.b%0d.sync", tag, i), {bursts[i].syncs[15:0], 15'd0, bursts[i].sync_last},
                {16'(v.wr ? 1 : 0), 15'd0, v.wr});
            chk($sformatf("%s.b%0d.stable", tag, i), 32'(bursts[i].unstable), 32'd0);
        end
        for (int j = 0; j < miso_q.size(); j++) begin
            exp_miso = 8'h00;
            if (!v.wr && j >= 6) begin
                a = v.addr + 32'(j - 6);
                exp_miso = a[7:0] ^ 8'h3C;
            end
            chk($sformatf("%s.miso%0d", tag, j), 32'(miso_q[j]), 32'(exp_miso));
        end
        chk($sformatf("%s.end_addr", tag), pi.addr, v.exp_end);
        chk($sformatf("%s.model_end", tag), pi.addr, v.addr + 32'(nacc));
        chk($sformatf("%s.busy", tag), 32'(busy), 32'd0);
        chk($sformatf("%s.stray", tag), 32'(stray), 32'd0);
    endtask

    vec_t vecs[11];
    vec_t v;

    initial begin
        // Directed packets with hand-computed end addresses.
        vecs[0] = '{wr: 1'b1, addr: 32'h0100_0010, n: 2, data: 32'hA55A_0000, exp_end: 32'h0100_0012};
        vecs[1] = '{wr: 1'b0, addr: 32'h0180_0000, n: 4, data: 32'h0,        exp_end: 32'h0180_0005};
        vecs[2] = '{wr: 1'b1, addr: 32'hFFFF_FFFF, n: 2, data: 32'h1122_0000, exp_end: 32'h0000_0001};
        for (int i = 3; i < 11; i++) begin
            vecs[i].wr   = 1'($urandom_range(0, 1));
            vecs[i].addr = (i == 5) ? 32'hFFFF_FFFE : 32'($urandom);
            vecs[i].n    = int'($urandom_range(1, 4));
            vecs[i].data = 32'($urandom);
            vecs[i].exp_end = vecs[i].addr + 32'(vecs[i].wr ? vecs[i].n : vecs[i].n + 1);
        end

        // Reset state.
        tick(5);
        chk("rst.addr", pi.addr, 32'd0);
        chk("rst.ctl", {18'd0, pi.dato, pi.oe, pi.we, pi.act, pi.we_sync, spi_miso, busy}, 32'd0);
        rst_n = 1'b1;
        tick(5);
        chk("rst.busy_idle", 32'(busy), 32'd0);

        for (int i = 0; i < 11; i++) begin
            run_packet(vecs[i], $sformatf("vec%0d", i));
        end

        // SS rises while a write cycle is on the bus.
        bursts.delete();
        spi_start();
        begin
            logic [7:0] r;
            spi_bits(8'h80, 8, r);
            spi_bits(8'h12, 8, r);
            spi_bits(8'h34, 8, r);
            spi_bits(8'h56, 8, r);
            spi_bits(8'h78, 8, r);
        end
        spi_byte_hold(8'hC3);
        wait_bus("ssmid.wait_we");
        spi_ss = 1'b1;
        tick(HALF);
        spi_sck = 1'b0;
        tick(4 * HALF);
        chk("ssmid.bursts", 32'(bursts.size()), 32'd1);
        if (bursts.size() > 0) begin
            chk("ssmid.len", 32'(bursts[0].len), 32'(ACC_CYC));
            chk("ssmid.addr", bursts[0].addr, 32'h1234_5678);
            chk("ssmid.dato", 32'(bursts[0].dato), 32'hC3);
        end
        chk("ssmid.busy", 32'(busy), 32'd0);
        chk("ssmid.next_addr", pi.addr, 32'h1234_5679);
        v = '{wr: 1'b1, addr: 32'h0000_0200, n: 1, data: 32'h6600_0000, exp_end: 32'h0000_0201};
        run_packet(v, "ssmid.after");

        // Reset asserted while oe is active.
        spi_start();
        begin
            logic [7:0] r;
            spi_bits(8'h00, 8, r);
            spi_bits(8'h01, 8, r);
            spi_bits(8'h80, 8, r);
            spi_bits(8'h00, 8, r);
        end
        spi_byte_hold(8'h40);
        wait_bus("arst.wait_oe");
        rst_n = 1'b0;
        #1;
        chk("arst.ctl", {28'd0, pi.oe, pi.we, pi.act, busy}, 32'd0);
        chk("arst.addr", pi.addr, 32'd0);
        spi_ss  = 1'b1;
        spi_sck = 1'b0;
        tick(4);
        rst_n = 1'b1;
        tick(10);
        v = '{wr: 1'b0, addr: 32'h0000_00F0, n: 3, data: 32'h0, exp_end: 32'h0000_00F4};
        run_packet(v, "arst.after");

        // Partial packet: SS raised after two address bytes.
        bursts.delete();
        stray = 0;
        spi_start();
        begin
            logic [7:0] r;
            spi_bits(8'h80, 8, r);
            spi_bits(8'hAA, 8, r);
            spi_bits(8'hBB, 8, r);
        end
        spi_stop();
        chk("partial.bursts", 32'(bursts.size()), 32'd0);
        chk("partial.busy", 32'(busy), 32'd0);
        chk("partial.stray", 32'(stray), 32'd0);
        v = '{wr: 1'b1, addr: 32'h00C0_FFEE, n: 1, data: 32'h9900_0000, exp_end: 32'h00C0_FFEF};
        run_packet(v, "partial.after");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
